// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester bridge: FSM states, the buffered
// command payload and the default bus / wait-counter widths.
package apb_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned WAIT_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_state_e;

  // Command payload held in the buffer; sized for the default bus widths.
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } apb_cmd_t;

  localparam int unsigned CMD_W = $bits(apb_cmd_t);

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command buffer: pointer/count synchronous FIFO with registered flags.
//   PCLK, PRESET     clock, asynchronous active-high reset
//   push, din        write side (push while full is taken only with a pop)
//   pop, dout        read side, dout shows the current head
//   not_full, empty  registered occupancy flags
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = CMD_W
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         not_full,
  output logic         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot, so a push is legal while full if a pop coincides.
  assign do_push = push && (not_full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Next occupancy
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, count and flags; flags derive only from the next count
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      not_full <= 1'b1;
      empty    <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q  <= count_d;
      not_full <= (count_d != CNT_W'(DEPTH));
      empty    <= (count_d == '0);
    end
  end

  // Storage array
  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester bridge: buffers valid/ready commands, runs one SETUP/ACCESS
// transfer per command and returns read data / error on a response stream.
//   PCLK, PRESET                     clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata command stream (cmd_ready = buffer not full)
//   rsp_valid/ready/rdata/err        response stream
//   PSEL PENABLE PWRITE PADDR PWDATA APB request outputs (all registered)
//   PRDATA PREADY PSLVERR            APB completion inputs
// Widths up to the package defaults are carried through the command buffer.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d;
  logic              rsp_valid_d, err_d;
  logic [DATA_W-1:0] rdata_d;
  logic              load_c;
  logic [ADDR_W-1:0] head_addr;

  apb_cmd_t          cmd_in;
  apb_cmd_t          head;
  logic [CMD_W-1:0]  fifo_dout;
  logic              fifo_empty;
  logic              fifo_not_full;
  logic              push;

  // Pack the incoming command into the buffer payload
  always_comb begin
    cmd_in.write = cmd_write;
    cmd_in.addr  = DEF_ADDR_W'(cmd_addr);
    cmd_in.wdata = DEF_DATA_W'(cmd_wdata);
  end

  assign cmd_ready = fifo_not_full;
  assign push      = cmd_valid && fifo_not_full;
  assign head      = apb_cmd_t'(fifo_dout);

  apb_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .push     (push),
    .din      (cmd_in),
    .pop      (load_c),
    .dout     (fifo_dout),
    .not_full (fifo_not_full),
    .empty    (fifo_empty)
  );

  // Next state and next values of every registered output
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    load_c      = 1'b0;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rsp_valid_d = rsp_valid;
    rdata_d     = rsp_rdata;
    err_d       = rsp_err;
    head_addr   = ADDR_W'(head.addr);

    unique case (state_q)
      ST_IDLE: load_c = !fifo_empty;
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = PSLVERR;
          rdata_d     = (PWRITE || PSLVERR) ? '0 : PRDATA;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          // This edge ends the TIMEOUT-th stalled ACCESS cycle: abort.
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          rdata_d     = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (fifo_empty) state_d = ST_IDLE;
          else            load_c  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop the head into the transfer registers and start SETUP
    if (load_c) begin
      state_d   = ST_SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = head.write;
      paddr_d   = {head_addr[ADDR_W-1:2], 2'b00};
      pwdata_d  = DATA_W'(head.wdata);
      wait_d    = '0;
    end
  end

  // State and output registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
    end
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB3 requester (master) bridge: converts a simple valid/ready command stream into single APB transfers and returns the read data and error status on a valid/ready response stream. It sits between the Cortex-M3 subsystem's internal command path and the APB peripheral segment (GPIO, LPR control registers), driving the SETUP/ACCESS phases that the APB slaves answer. It buffers up to two commands, honours PREADY wait states, and aborts stuck transfers with a timeout.

## Interface
Parameters:
- ADDR_W, 12, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 255, ACCESS cycles with PREADY low before abort (1..65535)
- FIFO_DEPTH, 2, command buffer entries (power of two, ≥2)

Ports:
- PCLK  in  1  sole clock, rising edge
- PRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  buffer not full
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_err  out  1  PSLVERR seen or timeout
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- Command accepted on cmd_valid & cmd_ready and pushed into the FIFO. cmd_ready = FIFO not full, registered from FIFO count only, with no combinational path from cmd_valid.
- PADDR = {addr[ADDR_W-1:2], 2'b00}. Bits [1:0] are ignored.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE → SETUP when the FIFO is non-empty. The FIFO head is popped into the transfer registers (PADDR/PWRITE/PWDATA).
  - SETUP: PSEL=1, PENABLE=0. Always exactly one cycle, then → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=1 → RESP. Capture PRDATA (reads) and PSLVERR.
    - PREADY=0 → increment the wait counter. When the counter reaches TIMEOUT → RESP with rsp_err=1 and rsp_rdata=0.
  - RESP: PSEL=0, PENABLE=0, rsp_valid=1. On rsp_ready:
    - FIFO non-empty → SETUP directly, popping the next head.
    - FIFO empty → IDLE.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS. They keep their last value outside transfers.
- rsp_rdata and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
- Writes return rsp_rdata=0. rsp_err reflects PSLVERR.
- FIFO push and pop in the same cycle are legal when full, because the pop frees the slot. cmd_ready still shows "full" that cycle.

## Timing
- Reset values: PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cmd_ready=1. FSM in IDLE, FIFO empty, wait counter 0.
- PRESET mid-transfer takes effect asynchronously: all outputs go to reset values immediately. Buffered commands and any pending response are discarded with no response.
- Latency with a zero-wait slave: command accepted at edge N → SETUP cycle N+1, ACCESS cycle N+2, rsp_valid high from edge N+3. Each PREADY wait cycle adds 1.
- Back-to-back with rsp_ready held high:
  - One RESP cycle between transfers, so each transfer occupies 3 cycles.
  - PSEL drops for that RESP cycle.
- Timeout: the abort edge is the one ending the TIMEOUT-th consecutive PREADY=0 ACCESS cycle. The wait counter clears on entry to SETUP.
- Only the PSLVERR sampled with PREADY=1 counts.

## Structure
- Shared package apb_pkg:
  - FSM state enum (IDLE/SETUP/ACCESS/RESP).
  - Command struct {write, addr, wdata}.
  - Default widths ADDR_W/DATA_W.
  - Wait-counter width constant, 16 bits.
- Sub-module apb_cmd_fifo: synchronous FIFO with FIFO_DEPTH entries, pointer/count based, full/empty flags, async active-high reset. The FSM and APB output registers stay in apb_master_bridge.

## Test plan
- Write through to the APB GPIO slave: cmd write addr 0x004 data 0x0000_0005 → one SETUP + one ACCESS cycle, PADDR=0x004, PWDATA=5. GPIO outputs become 3'b101. rsp_valid with rsp_err=0, rsp_rdata=0.
- Read: GPIO inputs = 4'hA, cmd read addr 0x000 → rsp_rdata=0x0000_000A, rsp_err=0, rsp_valid at accept edge +3.
- Wait states: slave holds PREADY=0 for 4 ACCESS cycles on a read of 0x1234_5678 → PADDR/PSEL/PENABLE stable throughout. rsp_rdata=0x1234_5678 at accept edge +7.
- Timeout and error, with TIMEOUT=8:
  - PREADY stuck low → abort after 8 ACCESS cycles, rsp_err=1, rsp_rdata=0. The next command proceeds normally.
  - Separately, PSLVERR=1 with PREADY=1 → rsp_err=1.
- Buffering and backpressure:
  - Issue 3 commands back to back with rsp_ready=0 → cmd_ready low after 2 buffered commands (one in flight). Only the first transfer is on APB.
  - Release rsp_ready → remaining transfers issued in order with 3-cycle spacing.
- Reset mid-ACCESS: assert PRESET while PSEL=PENABLE=1 with 1 command queued → outputs zero in the same cycle, no rsp_valid after release, cmd_ready=1.
